// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// one-hot {c, agb, alb} result encoding.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  typedef logic [2:0] result_t;

  localparam result_t EQ   = 3'b100;
  localparam result_t GT   = 3'b010;
  localparam result_t LT   = 3'b001;
  localparam result_t NONE = 3'b000;

  // Collapse the bit cell flags into the registered result word.
  function automatic result_t encode(input logic eq, input logic gt, input logic lt);
    if (eq)      return EQ;
    else if (gt) return GT;
    else if (lt) return LT;
    else         return NONE;
  endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// Single bit-pair comparison; the MSB of a signed operand carries negative
// weight, so its sense is inverted there.
module comp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_msb,
  input  logic signed_mode,
  output logic eq,
  output logic gt,
  output logic lt
);

  logic flip;

  assign flip = signed_mode & is_msb;
  assign eq   = (a_bit == b_bit);
  assign gt   = !eq && (a_bit ^ flip);
  assign lt   = !eq && !(a_bit ^ flip);

endmodule

// File: rtl/comp_nbit_serial.sv
// Serial comparator: scans latched operands MSB first, one bit per cycle,
// and stops at the first differing bit.
module comp_nbit_serial
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             c,
  output logic             agb,
  output logic             alb
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic            sm_q;
  logic [IW-1:0]   idx_q;
  result_t         res_q;
  logic            load, finish;
  logic            cell_eq, cell_gt, cell_lt;

  comp_bit_cell u_cell (
    .a_bit       (a_q[idx_q]),
    .b_bit       (b_q[idx_q]),
    .is_msb      (idx_q == MSB_IDX),
    .signed_mode (sm_q),
    .eq          (cell_eq),
    .gt          (cell_gt),
    .lt          (cell_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          load    = 1'b1;
        end
      end
      SCAN: begin
        // Early exit: a difference decides immediately, lower bits are never visited.
        if (!cell_eq || idx_q == '0) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = SCAN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
      idx_q <= '0;
      res_q <= NONE;
    end else begin
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        sm_q  <= signed_mode;
        idx_q <= MSB_IDX;
      end else if (state_q == SCAN && !finish) begin
        idx_q <= idx_q - 1'b1;
      end
      if (finish) res_q <= encode(cell_eq, cell_gt, cell_lt);
    end
  end

  assign c   = res_q[2];
  assign agb = res_q[1];
  assign alb = res_q[0];

endmodule

// File: tb/tb_comp_nbit_serial.sv
// Self-checking bench for comp_nbit_serial: directed cases followed by
// randomized comparisons checked against an arithmetic reference model.
module tb_comp_nbit_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, signed_mode;
  logic [W-1:0] a, b;
  logic         busy, done, c, agb, alb;

  int           total = 0;
  int           bad = 0;
  logic [2:0]   held = 3'b000;

  always #5 clk = ~clk;

  comp_nbit_serial #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .c           (c),
    .agb         (agb),
    .alb         (alb)
  );

  // Reference: relation from plain integer compare, latency from the
  // position of the highest differing bit.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic sm, output logic [2:0] res, output int lat);
    logic [W-1:0] x;
    int k;
    bit found;
    x = av ^ bv;
    k = 0;
    found = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        k = i;
        found = 1;
      end
    end
    if (av == bv) begin
      res = 3'b100;
      lat = W;
    end else begin
      lat = W - k;
      if (sm) res = ($signed(av) > $signed(bv)) ? 3'b010 : 3'b001;
      else    res = (av > bv) ? 3'b010 : 3'b001;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] exp);
    total++;
    assert ({busy, done, c, agb, alb} === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed={busy,done,c,agb,alb}=%b expected=%b",
             tag, {busy, done, c, agb, alb}, exp);
    end
  endtask

  // Launch one comparison and follow it cycle by cycle until done.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic sm, input bit scramble, input bit repulse,
                               input string tag);
    logic [2:0] res;
    int lat;
    model(av, bv, sm, res, lat);
    a = av;
    b = bv;
    signed_mode = sm;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, "/accept"}, {2'b10, held});
    for (int i = 1; i <= lat; i++) begin
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        start = 1'($urandom);
      end
      if (repulse) begin
        start = (i == 3);
        if (i == 3) begin
          a = 8'hFF;
          b = 8'h00;
        end
      end
      tick();
      if (i < lat) begin
        checkOutput({tag, "/scan"}, {2'b10, held});
      end else begin
        held = res;
        checkOutput({tag, "/done"}, {2'b01, held});
      end
    end
    start = 1'b0;
  endtask

  task automatic idleCycle(input string tag);
    start = 1'b0;
    tick();
    checkOutput({tag, "/idle"}, {2'b00, held});
  endtask

  initial begin
    logic [W-1:0] av, bv;
    rst_n = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    checkOutput("reset", 5'b00000);
    start = 1'b1;
    tick();
    checkOutput("start_in_reset", 5'b00000);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    checkOutput("idle_after_reset", 5'b00000);

    applyStimulus(8'hA5, 8'hA5, 1'b0, 0, 0, "eq_a5");
    idleCycle("eq_a5");
    applyStimulus(8'h80, 8'h7F, 1'b0, 0, 0, "u_80_7f");
    idleCycle("u_80_7f");
    applyStimulus(8'h80, 8'h7F, 1'b1, 0, 0, "s_80_7f");
    idleCycle("s_80_7f");
    applyStimulus(8'h12, 8'h13, 1'b0, 0, 0, "u_12_13");
    idleCycle("u_12_13");
    applyStimulus(8'h40, 8'h41, 1'b0, 1, 1, "repulse");
    idleCycle("repulse");

    // Reset asserted so that it is sampled at the end of the third scan cycle.
    a = 8'h40;
    b = 8'h41;
    signed_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("abort/scan1", {2'b10, held});
    tick();
    checkOutput("abort/scan2", {2'b10, held});
    tick();
    checkOutput("abort/scan3", {2'b10, held});
    rst_n = 1'b0;
    tick();
    held = 3'b000;
    checkOutput("abort/reset", 5'b00000);
    rst_n = 1'b1;
    tick();
    checkOutput("abort/no_done", 5'b00000);

    applyStimulus(8'h01, 8'h00, 1'b0, 0, 0, "post_reset");
    applyStimulus(8'h7F, 8'hFF, 1'b1, 0, 0, "back_to_back");
    idleCycle("back_to_back");

    for (int n = 0; n < 60; n++) begin
      av = W'($urandom);
      case ($urandom_range(2, 0))
        0:       bv = av;
        1:       bv = av ^ W'(1 << $urandom_range(W - 1, 0));
        default: bv = W'($urandom);
      endcase
      applyStimulus(av, bv, 1'($urandom), 1, 0, "random");
      if ($urandom_range(1, 0) == 1) idleCycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
